vga_driver_param: RTL and testbench



---
 rtl/vga_driver_param_if.sv | 17 +
 rtl/vga_driver_param.sv | 132 +++++++++++++
 tb/tb_vga_driver_param.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_driver_param_if.sv
// vga_driver_param_if: framebuffer read bus plus VGA DAC pin bundle.
interface vga_driver_param_if #(
  parameter int COLOR_W = 5,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 19
);
  logic [ADDR_W-1:0]  addr;
  logic [IDX_W-1:0]   data;
  logic               vga_hsync;
  logic               vga_vsync;
  logic               frame_start;
  logic [COLOR_W-1:0] vga_red;
  logic [COLOR_W-1:0] vga_green;
  logic [COLOR_W-1:0] vga_blue;
  modport master(output addr, vga_hsync, vga_vsync, frame_start, vga_red, vga_green, vga_blue, input data);
  modport slave(input addr, vga_hsync, vga_vsync, frame_start, vga_red, vga_green, vga_blue, output data);
endinterface

// File: rtl/vga_driver_param.sv
// vga_driver_param: programmable VGA timing, scaled framebuffer addressing and palette lookup.
// Optional VGA_TEST_PATTERN_EN adds test_mode, replacing the palette with 8 vertical colour bars.
module vga_driver_param #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   COLOR_W  = 5,
  parameter int   IDX_W    = 4,
  parameter int   SCALE    = 1,
  parameter int   RAM_LAT  = 1,
  parameter int   ADDR_W   = 19
) (
  input  logic                 pixel_clk,
  input  logic                 rst_pixel_n,
  input  logic                 enable,
  input  logic                 pal_we,
  input  logic [IDX_W-1:0]     pal_idx,
  input  logic [3*COLOR_W-1:0] pal_color,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  vga_driver_param_if.master   vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW3 = 3 * COLOR_W;
  localparam int NPAL = 2 ** IDX_W;

  typedef struct packed {
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
    logic first;
    logic en;
    logic de;
    logic vs;
    logic hs;
  } stage_t;

  function automatic logic [CW3-1:0] gray(input int i);
    logic [COLOR_W-1:0] c;
    c = COLOR_W'(i * (2 ** COLOR_W - 1) / (2 ** IDX_W - 1));
    return {c, c, c};
  endfunction

  logic [HW-1:0] sx;
  logic [VW-1:0] sy;
  logic          vid_en;
  logic          last_x;
  logic          last_y;
  logic          de;
  stage_t        cur;
  stage_t        po;
  stage_t        pipe [RAM_LAT+1];
  logic [CW3-1:0] pal [NPAL];
  logic [CW3-1:0] rgb;
  logic [CW3-1:0] pix_sel;
  logic [CW3-1:0] pix;

  assign last_x = sx == HW'(H_TOTAL - 1);
  assign last_y = sy == VW'(V_TOTAL - 1);
  assign de = (32'(sx) < H_ACTIVE) && (32'(sy) < V_ACTIVE);
  assign vga.addr = de ? ADDR_W'((32'(sy) / SCALE) * (H_ACTIVE / SCALE) + 32'(sx) / SCALE) : '0;

  always_ff @(posedge pixel_clk or negedge rst_pixel_n)
    if (!rst_pixel_n) begin
      sx <= '0;
      sy <= '0;
      vid_en <= 1'b1;
    end else begin
      sx <= last_x ? '0 : sx + 1'b1;
      if (last_x) sy <= last_y ? '0 : sy + 1'b1;
      if (last_x && last_y) vid_en <= enable;
    end

  always_comb begin
    cur = '0;
    cur.hs = (32'(sx) >= H_ACTIVE + H_FP && 32'(sx) < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    cur.vs = (32'(sy) >= V_ACTIVE + V_FP && 32'(sy) < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    cur.de = de;
    cur.en = vid_en;
    cur.first = (sx == '0) && (sy == '0);
`ifdef VGA_TEST_PATTERN_EN
    cur.bar = 3'(32'(sx) / (H_ACTIVE / 8));
`endif
  end

  // Timing bits ride alongside the RAM read so the final stage lines up with the registered colour
  always_ff @(posedge pixel_clk or negedge rst_pixel_n)
    if (!rst_pixel_n) begin
      for (int i = 0; i <= RAM_LAT; i++) begin
        pipe[i] <= '0;
        pipe[i].hs <= ~SYNC_POL;
        pipe[i].vs <= ~SYNC_POL;
      end
      for (int i = 0; i < NPAL; i++) pal[i] <= gray(i);
      rgb <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i <= RAM_LAT; i++) pipe[i] <= pipe[i-1];
      rgb <= pal[vga.data];
      if (pal_we) pal[pal_idx] <= pal_color;
    end

  assign po = pipe[RAM_LAT];

`ifdef VGA_TEST_PATTERN_EN
  logic tm;
  always_ff @(posedge pixel_clk or negedge rst_pixel_n)
    if (!rst_pixel_n) tm <= 1'b0;
    else tm <= test_mode;
  assign pix_sel = tm ? {{COLOR_W{po.bar[2]}}, {COLOR_W{po.bar[1]}}, {COLOR_W{po.bar[0]}}} : rgb;
`else
  assign pix_sel = rgb;
`endif

  assign pix = (po.de && po.en) ? pix_sel : '0;
  assign vga.vga_red = pix[CW3-1 -: COLOR_W];
  assign vga.vga_green = pix[2*COLOR_W-1 -: COLOR_W];
  assign vga.vga_blue = pix[COLOR_W-1:0];
  assign vga.vga_hsync = po.hs;
  assign vga.vga_vsync = po.vs;
  assign vga.frame_start = po.first && po.en;
endmodule

// File: tb/tb_vga_driver_param.sv
// tb_vga_driver_param: scoreboard bench on a shrunken 24x12 timing with SCALE=2, RAM_LAT=3.
module tb_vga_driver_param;
  localparam int HA = 16, HFP = 2, HS = 3, HB = 3, VA = 8, VFP = 1, VS = 2, VB = 1;
  localparam int HT = HA + HFP + HS + HB, VT = VA + VFP + VS + VB, FR = HT * VT;
  localparam int CW = 5, IW = 4, SC = 2, LAT = 3, AW = 8;

  logic pixel_clk = 1'b0;
  logic rst_pixel_n = 1'b0;
  logic enable = 1'b1;
  logic pal_we = 1'b0;
  logic [IW-1:0] pal_idx = '0;
  logic [3*CW-1:0] pal_color = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif
  logic [3*CW-1:0] pins;
  int n_cmp = 0, n_bad = 0;

  vga_driver_param_if #(.COLOR_W(CW), .IDX_W(IW), .ADDR_W(AW)) bus();

  vga_driver_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(CW), .IDX_W(IW), .SCALE(SC), .RAM_LAT(LAT), .ADDR_W(AW)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst_pixel_n(rst_pixel_n),
    .enable(enable),
    .pal_we(pal_we),
    .pal_idx(pal_idx),
    .pal_color(pal_color),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .vga(bus)
  );

  always #5 pixel_clk = ~pixel_clk;
  assign pins = {bus.vga_red, bus.vga_green, bus.vga_blue};

  // Framebuffer RAM with LAT-cycle read latency
  logic [IW-1:0] mem [2**AW];
  logic [IW-1:0] ram_q [LAT];
  always @(posedge pixel_clk) begin
    ram_q[0] <= mem[bus.addr];
    for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign bus.data = ram_q[LAT-1];

  function automatic int exp_addr(int x, int y);
    return (x < HA && y < VA) ? (y / SC) * (HA / SC) + x / SC : 0;
  endfunction

  typedef struct packed {
    logic hs, vs, de, en, fs;
    logic [IW-1:0] idx;
    logic [3*CW-1:0] rgb;
  } exp_t;

  exp_t q[$];
  exp_t cur, e;
  logic cur_v;
  logic [3*CW-1:0] pal_m [2**IW];
  int msx, msy, cyc;
  logic men;

  // Reference model: one entry per counter position, colour resolved in the RAM-read cycle
  initial forever begin
    if (!rst_pixel_n) begin
      q.delete();
      cur = '0;
      cur_v = 1'b0;
      msx = 0;
      msy = 0;
      cyc = 0;
      men = 1'b1;
      for (int i = 0; i < 2**IW; i++) pal_m[i] = {3{CW'(i * 31 / 15)}};
    end else begin
      e.de = msx < HA && msy < VA;
      e.hs = !(msx >= HA + HFP && msx < HA + HFP + HS);
      e.vs = !(msy >= VA + VFP && msy < VA + VFP + VS);
      e.en = men;
      e.fs = msx == 0 && msy == 0 && men;
      e.idx = mem[exp_addr(msx, msy)];
      e.rgb = '0;
      q.push_back(e);
      if (q.size() > LAT) begin
        cur = q.pop_front();
        cur.rgb = (cur.de && cur.en) ? pal_m[cur.idx] : '0;
        cur_v = 1'b1;
      end
      if (pal_we) pal_m[pal_idx] = pal_color;
      if (msx == HT - 1 && msy == VT - 1) men = enable;
      msy = (msx == HT - 1) ? ((msy == VT - 1) ? 0 : msy + 1) : msy;
      msx = (msx == HT - 1) ? 0 : msx + 1;
      cyc++;
    end
    @(posedge pixel_clk or negedge rst_pixel_n);
  end

  task automatic test_reset;
    rst_pixel_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    n_cmp++;
    if ({bus.vga_hsync, bus.vga_vsync} !== 2'b11) begin
      n_bad++; $display("FAIL reset_sync: got %b want 11", {bus.vga_hsync, bus.vga_vsync});
    end
    n_cmp++;
    if (pins !== '0 || bus.frame_start !== 1'b0) begin
      n_bad++; $display("FAIL reset_rgb_fs: got rgb=%h fs=%b want 0 0", pins, bus.frame_start);
    end
    n_cmp++;
    if (bus.addr !== '0) begin
      n_bad++; $display("FAIL reset_addr: got %0d want 0", bus.addr);
    end
    rst_pixel_n = 1'b1;
  endtask

  task automatic test_latency;
    while (cyc < 3) @(negedge pixel_clk);
    n_cmp++;
    if (pins !== '0 || bus.frame_start !== 1'b0) begin
      n_bad++; $display("FAIL lat_early: cyc3 rgb=%h fs=%b want 0 0", pins, bus.frame_start);
    end
    @(negedge pixel_clk);
    n_cmp++;
    if (pins !== 15'h7FFF || bus.frame_start !== 1'b1) begin
      n_bad++; $display("FAIL lat_first: cyc4 rgb=%h fs=%b want 7fff 1", pins, bus.frame_start);
    end
    @(negedge pixel_clk);
    n_cmp++;
    if (bus.frame_start !== 1'b0) begin
      n_bad++; $display("FAIL lat_pulse: cyc5 fs=%b want 0", bus.frame_start);
    end
  endtask

  task automatic test_timing;
    int t, w;
    t = -1;
    while (cyc < 100 && t < 0) begin
      @(negedge pixel_clk);
      if (bus.vga_hsync === 1'b0) t = cyc;
    end
    n_cmp++;
    if (t != HA + HFP + LAT + 1) begin
      n_bad++; $display("FAIL hsync_start: got %0d want %0d", t, HA + HFP + LAT + 1);
    end
    w = 0;
    while (bus.vga_hsync === 1'b0 && w < 100) begin w++; @(negedge pixel_clk); end
    n_cmp++;
    if (w != HS) begin
      n_bad++; $display("FAIL hsync_width: got %0d want %0d", w, HS);
    end
    t = -1;
    while (cyc < 200 && t < 0) begin
      @(negedge pixel_clk);
      if (bus.vga_hsync === 1'b0) t = cyc;
    end
    n_cmp++;
    if (t != HA + HFP + LAT + 1 + HT) begin
      n_bad++; $display("FAIL hsync_period: got %0d want %0d", t, HA + HFP + LAT + 1 + HT);
    end
    t = -1;
    while (cyc < 600 && t < 0) begin
      @(negedge pixel_clk);
      if (bus.vga_vsync === 1'b0) t = cyc;
    end
    n_cmp++;
    if (t != (VA + VFP) * HT + LAT + 1) begin
      n_bad++; $display("FAIL vsync_start: got %0d want %0d", t, (VA + VFP) * HT + LAT + 1);
    end
    w = 0;
    while (bus.vga_vsync === 1'b0 && w < 200) begin w++; @(negedge pixel_clk); end
    n_cmp++;
    if (w != VS * HT) begin
      n_bad++; $display("FAIL vsync_width: got %0d want %0d", w, VS * HT);
    end
    t = -1;
    while (cyc < 1000 && t < 0) begin
      @(negedge pixel_clk);
      if (bus.vga_vsync === 1'b0) t = cyc;
    end
    n_cmp++;
    if (t != (VA + VFP) * HT + LAT + 1 + FR) begin
      n_bad++; $display("FAIL vsync_period: got %0d want %0d", t, (VA + VFP) * HT + LAT + 1 + FR);
    end
  endtask

  task automatic test_scale_addr;
    int px[5] = '{4, 5, 15, 16, 0};
    int py[5] = '{2, 3, 7, 7, 8};
    int pa[5] = '{10, 10, 31, 0, 0};
    int n;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!(msx == px[k] && msy == py[k]) && n < 400) begin @(negedge pixel_clk); n++; end
      n_cmp++;
      if (n >= 400 || bus.addr !== AW'(pa[k])) begin
        n_bad++; $display("FAIL addr_%0d_%0d: got %0d want %0d", px[k], py[k], bus.addr, pa[k]);
      end
    end
  endtask

  task automatic test_palette;
    int n = 0;
    while (!(msx == 6 && msy == 1) && n < 400) begin @(negedge pixel_clk); n++; end
    repeat (3) @(posedge pixel_clk);
    #1;
    pal_we = 1'b1; pal_idx = 4'd2; pal_color = 15'h7C00;
    @(posedge pixel_clk);
    #1;
    pal_we = 1'b0;
    @(negedge pixel_clk);
    n_cmp++;
    if (n >= 400 || pins !== 15'h1084) begin
      n_bad++; $display("FAIL pal_same_cycle: got %h want 1084", pins);
    end
    @(negedge pixel_clk);
    n_cmp++;
    if (bus.vga_red !== 5'd31 || bus.vga_green !== 5'd0 || bus.vga_blue !== 5'd0) begin
      n_bad++; $display("FAIL pal_new: got r=%0d g=%0d b=%0d want 31 0 0", bus.vga_red, bus.vga_green, bus.vga_blue);
    end
  endtask

  task automatic test_enable;
    int n = 0, nz = 0, nfs = 0, nh = 0, nv = 0;
    while (!(msx == 0 && msy == 4) && n < 400) begin @(negedge pixel_clk); n++; end
    enable = 1'b0;
    while (!(msx == 0 && msy == 0) && n < 800) begin
      if (pins !== '0) nz++;
      @(negedge pixel_clk); n++;
    end
    n_cmp++;
    if (n >= 800 || nz == 0) begin
      n_bad++; $display("FAIL en_keep: got %0d lit pixels want >0", nz);
    end
    nz = 0;
    for (int i = 0; i < FR; i++) begin
      if (pins !== '0) nz++;
      if (bus.frame_start === 1'b1) nfs++;
      if (bus.vga_hsync === 1'b0) nh++;
      if (bus.vga_vsync === 1'b0) nv++;
      if (msy == 6) enable = 1'b1;
      @(negedge pixel_clk);
    end
    n_cmp++;
    if (nz != 0 || nfs != 0) begin
      n_bad++; $display("FAIL en_black: got lit=%0d fs=%0d want 0 0", nz, nfs);
    end
    n_cmp++;
    if (nh != VT * HS || nv != VS * HT) begin
      n_bad++; $display("FAIL en_sync: got h=%0d v=%0d want %0d %0d", nh, nv, VT * HS, VS * HT);
    end
    nfs = 0;
    repeat (8) begin
      if (bus.frame_start === 1'b1) nfs++;
      @(negedge pixel_clk);
    end
    n_cmp++;
    if (nfs != 1) begin
      n_bad++; $display("FAIL en_resume: got %0d frame_start want 1", nfs);
    end
  endtask

  task automatic test_scoreboard;
    int shown = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(posedge pixel_clk);
      #1;
      pal_we = ($urandom_range(5) == 0);
      pal_idx = IW'($urandom);
      pal_color = 15'($urandom);
      if ($urandom_range(40) == 0) enable = ~enable;
      mem[$urandom_range(31)] = IW'($urandom);
      @(negedge pixel_clk);
      n_cmp++;
      if ({bus.vga_hsync, bus.vga_vsync, bus.frame_start, pins, bus.addr} !==
          {cur.hs, cur.vs, cur.fs, cur.rgb, AW'(exp_addr(msx, msy))}) begin
        n_bad++;
        if (shown++ < 20)
          $display("FAIL sb_cyc%0d: got hs=%b vs=%b fs=%b rgb=%h addr=%0d want %b %b %b %h %0d", cyc,
                   bus.vga_hsync, bus.vga_vsync, bus.frame_start, pins, bus.addr,
                   cur.hs, cur.vs, cur.fs, cur.rgb, exp_addr(msx, msy));
      end
    end
    @(posedge pixel_clk);
    #1;
    pal_we = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_async_reset;
    int n = 0, t = -1;
    while (pins === '0 && n < 800) begin @(negedge pixel_clk); n++; end
    #2 rst_pixel_n = 1'b0;
    #1;
    n_cmp++;
    if (n >= 800 || pins !== '0 || bus.frame_start !== 1'b0) begin
      n_bad++; $display("FAIL arst_rgb: got rgb=%h fs=%b want 0 0", pins, bus.frame_start);
    end
    repeat (2) @(negedge pixel_clk);
    rst_pixel_n = 1'b1;
    n = 0;
    while (bus.vga_hsync !== 1'b0 && n < 100) begin @(negedge pixel_clk); n++; end
    #2 rst_pixel_n = 1'b0;
    #1;
    n_cmp++;
    if (n >= 100 || {bus.vga_hsync, bus.vga_vsync} !== 2'b11) begin
      n_bad++; $display("FAIL arst_sync: got %b want 11", {bus.vga_hsync, bus.vga_vsync});
    end
    repeat (2) @(negedge pixel_clk);
    rst_pixel_n = 1'b1;
    while (cyc < 100 && t < 0) begin
      @(negedge pixel_clk);
      if (bus.vga_hsync === 1'b0) t = cyc;
    end
    n_cmp++;
    if (t != HA + HFP + LAT + 1) begin
      n_bad++; $display("FAIL arst_restart: got %0d want %0d", t, HA + HFP + LAT + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) mem[a] = IW'(a % 15 + 1);
    mem[0] = 4'hF;
    mem[3] = 4'd2;
    test_reset();
    test_latency();
    test_timing();
    test_scale_addr();
    test_palette();
    test_enable();
    test_scoreboard();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
